// File: rtl/fir_mac_seq_pkg.sv
// Shared types and constants for the FIR MAC sequencer.
// Holds the FSM state encoding, the MAC output-mux select codes, and the
// default parameter values used by fir_mac_sequencer.
package fir_mac_seq_pkg;

    // Default configuration of the sequencer.
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_TAP_W    = 8;
    localparam int DEF_MAX_TAPS = 255;
    localparam int DEF_MAC_LAT  = 2;

    // The MAC datapath and its operands are 16 bits wide.
    localparam int DATA_W = 16;

    // Operand pipe depth: memory read return, then operand register.
    localparam int VPIPE_DEPTH = 2;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_ACCUM   = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_CAPTURE = 3'd4
    } state_e;

    // MAC output-mux select codes.
    localparam logic [1:0] SELM_ADDER  = 2'b00;
    localparam logic [1:0] SELM_ACCUM  = 2'b01;
    localparam logic [1:0] SELM_MULT8  = 2'b10;
    localparam logic [1:0] SELM_MULT16 = 2'b11;

endpackage

// File: rtl/fir_mac_seq_vpipe.sv
// Valid/first-flag delay line for the FIR MAC sequencer.
// Delays the memory read strobe by DEPTH cycles so that it lines up with the
// registered operand pair; vld_o[0] marks read data returning, vld_o[DEPTH-1]
// marks the operand pair being presented to the MAC. The first flag travels
// with the valid bit and marks the pair that must load instead of accumulate.
// DEPTH must be at least 2.
module fir_mac_seq_vpipe #(
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             vld_i,
    input  logic             first_i,
    output logic [DEPTH-1:0] vld_o,
    output logic             first_o
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] first_q;

    // Shift register of valid and first flags; a flush empties every stage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q   <= '0;
            first_q <= '0;
        end else if (flush_i) begin
            vld_q   <= '0;
            first_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the
            // previous stage's old value, giving a true one-cycle-per-stage
            // shift regardless of statement order.
            vld_q   <= {vld_q[DEPTH-2:0], vld_i};
            first_q <= {first_q[DEPTH-2:0], vld_i & first_i};
        end
    end

    assign vld_o   = vld_q;
    assign first_o = first_q[DEPTH-1];

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR MAC sequencer: runs an N-tap dot product on the shared 16-bit MAC.
// Walks the coefficient memory upward from coef_base and the circular sample
// memory downward from samp_head, feeds registered operand pairs to the MAC
// with accumulate/clear controls, waits for the MAC latency, and captures the
// accumulator output behind a start/done handshake.
// Optional build macro FIR_MAC_SEQ_ABORT_EN adds abort_i / aborted_o.
module fir_mac_sequencer
    import fir_mac_seq_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int TAP_W    = DEF_TAP_W,
    parameter int MAX_TAPS = DEF_MAX_TAPS,
    parameter int MAC_LAT  = DEF_MAC_LAT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // Control handshake
    input  logic              start_i,
    input  logic [TAP_W-1:0]  n_taps_i,
    input  logic [ADDR_W-1:0] coef_base_i,
    input  logic [ADDR_W-1:0] samp_head_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic              result_valid_o,
`ifdef FIR_MAC_SEQ_ABORT_EN
    input  logic              abort_i,
    output logic              aborted_o,
`endif
    // Coefficient / sample memory read port
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] coef_addr_o,
    output logic [ADDR_W-1:0] samp_addr_o,
    input  logic [DATA_W-1:0] coef_rdata_i,
    input  logic [DATA_W-1:0] samp_rdata_i,
    // MAC datapath interface
    output logic [DATA_W-1:0] mac_a_o,
    output logic [DATA_W-1:0] mac_b_o,
    output logic              mac_acc_en_o,
    output logic              mac_acc_clr_o,
    output logic [1:0]        mac_selm_o,
    input  logic [DATA_W-1:0] mac_out_i
);

    // Drain counter holds MAC_LAT-1 down to 0.
    localparam int DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(MAC_LAT - 1);
    // Clamp limit compared one bit wider than n_taps so the comparison is
    // meaningful even when MAX_TAPS equals the largest TAP_W value.
    localparam logic [TAP_W:0] MAX_TAPS_C = (TAP_W + 1)'(MAX_TAPS);

    // FSM state and registered outputs
    state_e              state_q;
    logic                busy_q;
    logic                done_q;
    logic                result_valid_q;
    logic [DATA_W-1:0]   result_q;
    logic [1:0]          selm_q;
    logic                mem_rd_en_q;
    logic [ADDR_W-1:0]   coef_addr_q;
    logic [ADDR_W-1:0]   samp_addr_q;
    logic                first_issue_q;
    logic                zero_run_q;
    logic [TAP_W-1:0]    issue_left_q;
    logic [DRAIN_W-1:0]  drain_cnt_q;

    // Operand registers
    logic [DATA_W-1:0]   mac_a_q;
    logic [DATA_W-1:0]   mac_b_q;

    // Next-state helpers
    logic [TAP_W-1:0]    n_eff;
    logic [TAP_W-1:0]    issue_left_d;
    logic [ADDR_W-1:0]   coef_addr_d;
    logic [ADDR_W-1:0]   samp_addr_d;
    logic [DRAIN_W-1:0]  drain_cnt_d;

    // Valid pipe taps
    logic [VPIPE_DEPTH-1:0] pipe_vld;
    logic                   pipe_first;
    logic                   abort_req;

    // Requested tap count, clamped to MAX_TAPS.
    assign n_eff = ({1'b0, n_taps_i} > MAX_TAPS_C) ? MAX_TAPS_C[TAP_W-1:0] : n_taps_i;

    // Address walk: coefficients ascend, samples descend; both wrap naturally
    // at the memory depth.
    assign coef_addr_d  = coef_addr_q + ADDR_W'(1);
    assign samp_addr_d  = samp_addr_q - ADDR_W'(1);
    assign issue_left_d = issue_left_q - TAP_W'(1);
    assign drain_cnt_d  = drain_cnt_q - DRAIN_W'(1);

`ifdef FIR_MAC_SEQ_ABORT_EN
    logic aborted_q;

    // Abort only matters while a run is in flight.
    assign abort_req = abort_i && (state_q != ST_IDLE);

    // One-cycle acknowledge of an accepted abort.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= abort_req;
        end
    end

    assign aborted_o = aborted_q;
`else
    assign abort_req = 1'b0;
`endif

    // Sequencer FSM with registered control outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
            selm_q         <= SELM_ADDER;
            mem_rd_en_q    <= 1'b0;
            coef_addr_q    <= '0;
            samp_addr_q    <= '0;
            first_issue_q  <= 1'b0;
            zero_run_q     <= 1'b0;
            issue_left_q   <= '0;
            drain_cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort_req) begin
                // Drop the run; result and result_valid keep their old values.
                state_q       <= ST_IDLE;
                busy_q        <= 1'b0;
                selm_q        <= SELM_ADDER;
                mem_rd_en_q   <= 1'b0;
                first_issue_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_i) begin
                            result_valid_q <= 1'b0;
                            busy_q         <= 1'b1;
                            selm_q         <= SELM_ACCUM;
                            coef_addr_q    <= coef_base_i;
                            samp_addr_q    <= samp_head_i;
                            if (n_eff == '0) begin
                                // Empty filter: skip the datapath, report zero.
                                zero_run_q <= 1'b1;
                                state_q    <= ST_CAPTURE;
                            end else begin
                                zero_run_q    <= 1'b0;
                                mem_rd_en_q   <= 1'b1;
                                first_issue_q <= 1'b1;
                                issue_left_q  <= n_eff - TAP_W'(1);
                                state_q       <= ST_FETCH;
                            end
                        end
                    end

                    ST_FETCH: begin
                        // One read per cycle; the current cycle is an issue.
                        first_issue_q <= 1'b0;
                        if (issue_left_q == '0) begin
                            mem_rd_en_q <= 1'b0;
                            state_q     <= ST_ACCUM;
                        end else begin
                            coef_addr_q  <= coef_addr_d;
                            samp_addr_q  <= samp_addr_d;
                            issue_left_q <= issue_left_d;
                        end
                    end

                    ST_ACCUM: begin
                        // The last read is returning now, so the last operand
                        // pair reaches the MAC on the next cycle.
                        if (pipe_vld[0]) begin
                            drain_cnt_q <= DRAIN_INIT;
                            state_q     <= ST_DRAIN;
                        end
                    end

                    ST_DRAIN: begin
                        // Covers the MAC latency after the last pair.
                        if (drain_cnt_q == '0) begin
                            state_q <= ST_CAPTURE;
                        end else begin
                            drain_cnt_q <= drain_cnt_d;
                        end
                    end

                    ST_CAPTURE: begin
                        // mac_out now reflects the final accumulation.
                        result_q       <= zero_run_q ? '0 : mac_out_i;
                        done_q         <= 1'b1;
                        result_valid_q <= 1'b1;
                        busy_q         <= 1'b0;
                        selm_q         <= SELM_ADDER;
                        state_q        <= ST_IDLE;
                    end

                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        selm_q  <= SELM_ADDER;
                    end
                endcase
            end
        end
    end

    // Aligns the read strobe with the operand register stage.
    fir_mac_seq_vpipe #(
        .DEPTH (VPIPE_DEPTH)
    ) u_vpipe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (abort_req),
        .vld_i   (mem_rd_en_q),
        .first_i (first_issue_q),
        .vld_o   (pipe_vld),
        .first_o (pipe_first)
    );

    // Operand register: captures read data on the cycle it returns.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mac_a_q <= '0;
            mac_b_q <= '0;
        end else if (pipe_vld[0]) begin
            mac_a_q <= coef_rdata_i;
            mac_b_q <= samp_rdata_i;
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign mem_rd_en_o    = mem_rd_en_q;
    assign coef_addr_o    = coef_addr_q;
    assign samp_addr_o    = samp_addr_q;
    assign mac_a_o        = mac_a_q;
    assign mac_b_o        = mac_b_q;
    assign mac_acc_en_o   = pipe_vld[VPIPE_DEPTH-1];
    assign mac_acc_clr_o  = pipe_first;
    assign mac_selm_o     = selm_q;

endmodule
